// File: rtl/krms_rescale_pkg.sv
// Shared types and constants for the RMS-norm rescale stage.
// Holds the FSM encoding, int8 lane limits and the product-width rule.
package krms_rescale_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FILL       = 2'd1,
        WAIT_SCALE = 2'd2,
        DRAIN      = 2'd3
    } state_t;

    localparam int INT8_MAX   = 127;
    localparam int INT8_MIN   = -128;
    localparam int PROD_GUARD = 9;

    // int8 operand times a zero-extended unsigned scale needs SCALE_WIDTH+9 signed bits.
    function automatic int prod_width(input int scale_w);
        return scale_w + PROD_GUARD;
    endfunction

endpackage

// File: rtl/krms_rescale_lane.sv
// One lane of the rescale datapath: combinational multiply, plus the
// round/shift/saturate applied to the registered product held by the parent.
module krms_rescale_lane
    import krms_rescale_pkg::*;
#(
    parameter int SCALE_WIDTH = 24,
    parameter int SHIFT_WIDTH = 5,
    parameter int PROD_W      = prod_width(SCALE_WIDTH)
) (
    input  logic signed [7:0]             data,
    input  logic        [SCALE_WIDTH-1:0] scale,
    output logic signed [PROD_W-1:0]      prod,
    input  logic signed [PROD_W-1:0]      prod_p1,
    input  logic        [SHIFT_WIDTH-1:0] shift,
    output logic signed [7:0]             result
);

    localparam int SUM_W = PROD_W + 1;

    function automatic logic signed [7:0] sat_int8(input logic signed [SUM_W-1:0] v);
        if (v > SUM_W'(INT8_MAX)) begin
            return 8'(INT8_MAX);
        end
        if (v < SUM_W'(INT8_MIN)) begin
            return 8'(INT8_MIN);
        end
        return v[7:0];
    endfunction

    logic signed [PROD_W-1:0] data_ext;
    logic signed [PROD_W-1:0] scale_ext;
    logic signed [SUM_W-1:0]  bias;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  shifted;

    always_comb begin
        data_ext  = PROD_W'(data);
        scale_ext = PROD_W'($signed({1'b0, scale}));
        prod      = data_ext * scale_ext;
    end

    // One guard bit above the product keeps the rounding add from wrapping.
    always_comb begin
        bias = '0;
        if (shift != '0) begin
            bias = SUM_W'(1) <<< (shift - SHIFT_WIDTH'(1));
        end
        sum     = SUM_W'(prod_p1) + bias;
        shifted = sum >>> shift;
        result  = sat_int8(shifted);
    end

endmodule

// File: rtl/krms_rescale.sv
// Buffers an int8 vector until its reciprocal-RMS scale arrives, then replays
// it through a multiply/round/saturate pipeline onto a valid/ready output.
module krms_rescale
    import krms_rescale_pkg::*;
#(
    parameter int BUS_NUM        = 8,
    parameter int DATA_NUM_WIDTH = 10,
    parameter int SCALE_WIDTH    = 24,
    parameter int SHIFT_WIDTH    = 5,
    parameter int BUF_DEPTH      = 128
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [DATA_NUM_WIDTH-1:0]   k_len,
    input  logic [SHIFT_WIDTH-1:0]      out_shift,
    input  logic [BUS_NUM*8-1:0]        in_fixed_data,
    input  logic                        in_fixed_data_vld,
    input  logic [SCALE_WIDTH-1:0]      rc_scale,
    input  logic                        rc_scale_vld,
    output logic [BUS_NUM*8-1:0]        out_data,
    output logic [BUS_NUM-1:0]          out_lane_mask,
    output logic                        out_data_vld,
    input  logic                        out_rdy,
    output logic                        busy,
    output logic                        overflow_err
);

    localparam int BW     = BUS_NUM * 8;
    localparam int AW     = $clog2(BUF_DEPTH);
    localparam int CW     = DATA_NUM_WIDTH;
    localparam int PROD_W = prod_width(SCALE_WIDTH);

    state_t                   state;
    logic [CW-1:0]            k_q;
    logic [CW-1:0]            nbeats_q;
    logic [CW-1:0]            wr_cnt;
    logic [CW-1:0]            rd_cnt;
    logic [SHIFT_WIDTH-1:0]   shift_q;
    logic [SCALE_WIDTH-1:0]   scale_q;
    logic                     scale_ok;

    logic [CW:0]              k_round;
    logic [CW-1:0]            nbeats_calc;
    logic [CW-1:0]            k_rem;
    logic                     adv;
    logic                     wr_en;
    logic                     rd_issue;
    logic                     drain_done;

    logic [BW-1:0]            buf_mem [BUF_DEPTH];
    logic [BW-1:0]            data_p0;
    logic                     vld_p0;
    logic                     last_p0;
    logic signed [PROD_W-1:0] prod_c  [BUS_NUM];
    logic signed [PROD_W-1:0] prod_p1 [BUS_NUM];
    logic                     vld_p1;
    logic                     last_p1;
    logic signed [7:0]        res_c   [BUS_NUM];
    logic [BUS_NUM-1:0]       mask_c;
    logic [BW-1:0]            data_c;

    always_comb begin
        k_round     = {1'b0, k_len} + (CW+1)'(BUS_NUM - 1);
        nbeats_calc = CW'(k_round / (CW+1)'(BUS_NUM));
        k_rem       = k_q % CW'(BUS_NUM);
    end

    assign adv        = ~out_data_vld | out_rdy;
    assign wr_en      = (state == FILL) && in_fixed_data_vld && (wr_cnt < CW'(BUF_DEPTH));
    assign rd_issue   = (state == DRAIN) && adv && (rd_cnt != nbeats_q);
    assign drain_done = (state == DRAIN) && (rd_cnt == nbeats_q) && !vld_p0 && !vld_p1 && adv;

    // Control FSM, counters and latched per-vector configuration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            k_q          <= '0;
            nbeats_q     <= '0;
            shift_q      <= '0;
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            scale_q      <= '0;
            scale_ok     <= 1'b0;
            busy         <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            if (in_fixed_data_vld && !wr_en) begin
                overflow_err <= 1'b1;
            end
            if (rc_scale_vld && (state != IDLE)) begin
                scale_q  <= rc_scale;
                scale_ok <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start && (k_len != '0)) begin
                        k_q      <= k_len;
                        nbeats_q <= nbeats_calc;
                        shift_q  <= out_shift;
                        wr_cnt   <= '0;
                        rd_cnt   <= '0;
                        scale_ok <= 1'b0;
                        busy     <= 1'b1;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (wr_en) begin
                        wr_cnt <= wr_cnt + CW'(1);
                        if ((wr_cnt + CW'(1)) == nbeats_q) begin
                            state <= (scale_ok || rc_scale_vld) ? DRAIN : WAIT_SCALE;
                        end
                    end
                end
                WAIT_SCALE: begin
                    if (rc_scale_vld) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (rd_issue) begin
                        rd_cnt <= rd_cnt + CW'(1);
                    end
                    if (drain_done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[wr_cnt[AW-1:0]] <= in_fixed_data;
        end
    end

    // Stage p0: buffer read
    always_ff @(posedge clk) begin
        if (rd_issue) begin
            data_p0 <= buf_mem[rd_cnt[AW-1:0]];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BUS_NUM; gi++) begin : g_lane
            krms_rescale_lane #(
                .SCALE_WIDTH (SCALE_WIDTH),
                .SHIFT_WIDTH (SHIFT_WIDTH),
                .PROD_W      (PROD_W)
            ) u_lane (
                .data    ($signed(data_p0[gi*8 +: 8])),
                .scale   (scale_q),
                .prod    (prod_c[gi]),
                .prod_p1 (prod_p1[gi]),
                .shift   (shift_q),
                .result  (res_c[gi])
            );
        end
    endgenerate

    // Stage p1: lane products
    always_ff @(posedge clk) begin
        if (adv) begin
            for (int i = 0; i < BUS_NUM; i++) begin
                prod_p1[i] <= prod_c[i];
            end
        end
    end

    // Only the final beat of a vector can be partial.
    always_comb begin
        mask_c = '0;
        data_c = '0;
        for (int i = 0; i < BUS_NUM; i++) begin
            mask_c[i]       = !last_p1 || (k_rem == '0) || (CW'(i) < k_rem);
            data_c[i*8 +: 8] = mask_c[i] ? res_c[i] : 8'sd0;
        end
    end

    // Stage p2: registered outputs, frozen while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0        <= 1'b0;
            last_p0       <= 1'b0;
            vld_p1        <= 1'b0;
            last_p1       <= 1'b0;
            out_data_vld  <= 1'b0;
            out_data      <= '0;
            out_lane_mask <= '0;
        end else if (adv) begin
            vld_p0        <= rd_issue;
            last_p0       <= rd_issue && (rd_cnt == (nbeats_q - CW'(1)));
            vld_p1        <= vld_p0;
            last_p1       <= last_p0;
            out_data_vld  <= vld_p1;
            out_data      <= vld_p1 ? data_c : '0;
            out_lane_mask <= vld_p1 ? mask_c : '0;
        end
    end

endmodule

// File: tb/tb_krms_rescale.sv
// Bench for krms_rescale: directed and random vectors scored against an
// arithmetic reference of the rescale rule, plus error and reset cases.
`timescale 1ns/1ps
module tb_krms_rescale;

    localparam int BUS_NUM = 8;
    localparam int DNW     = 10;
    localparam int SW      = 24;
    localparam int SHW     = 5;
    localparam int DEPTH   = 128;
    localparam int BW      = BUS_NUM * 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [DNW-1:0]     k_len = '0;
    logic [SHW-1:0]     out_shift = '0;
    logic [BW-1:0]      in_fixed_data = '0;
    logic               in_fixed_data_vld = 1'b0;
    logic [SW-1:0]      rc_scale = '0;
    logic               rc_scale_vld = 1'b0;
    logic [BW-1:0]      out_data;
    logic [BUS_NUM-1:0] out_lane_mask;
    logic               out_data_vld;
    logic               out_rdy = 1'b1;
    logic               busy;
    logic               overflow_err;

    always #5 clk = ~clk;

    krms_rescale #(
        .BUS_NUM(BUS_NUM), .DATA_NUM_WIDTH(DNW), .SCALE_WIDTH(SW),
        .SHIFT_WIDTH(SHW), .BUF_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
        .out_shift(out_shift), .in_fixed_data(in_fixed_data),
        .in_fixed_data_vld(in_fixed_data_vld), .rc_scale(rc_scale),
        .rc_scale_vld(rc_scale_vld), .out_data(out_data),
        .out_lane_mask(out_lane_mask), .out_data_vld(out_data_vld),
        .out_rdy(out_rdy), .busy(busy), .overflow_err(overflow_err)
    );

    int checks = 0;
    int failures = 0;
    int vec [DEPTH][BUS_NUM];
    logic [BW-1:0]      cap0;
    logic [BUS_NUM-1:0] cap_mask_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // value = data*scale, rounded half-up at the shift point, clamped to int8
    function automatic int ref_rescale(input int d, input longint sc, input int sh);
        longint p;
        p = longint'(d) * sc;
        if (sh > 0) p = (p + (longint'(1) << (sh - 1))) >>> sh;
        if (p > 127) return 127;
        if (p < -128) return -128;
        return int'(p);
    endfunction

    function automatic logic [BW-1:0] exp_data(input int b, input int k, input longint sc, input int sh);
        logic [BW-1:0] v;
        v = '0;
        for (int l = 0; l < BUS_NUM; l++)
            if (b * BUS_NUM + l < k) v[l*8 +: 8] = 8'(ref_rescale(vec[b][l], sc, sh));
        return v;
    endfunction

    function automatic logic [BUS_NUM-1:0] exp_mask(input int b, input int k);
        logic [BUS_NUM-1:0] m;
        m = '0;
        for (int l = 0; l < BUS_NUM; l++) m[l] = (b * BUS_NUM + l < k);
        return m;
    endfunction

    function automatic logic [BW-1:0] pack_beat(input int b);
        logic [BW-1:0] v;
        for (int l = 0; l < BUS_NUM; l++) v[l*8 +: 8] = 8'(vec[b][l]);
        return v;
    endfunction

    task automatic fill_const(input int nb, input int even_v, input int odd_v);
        for (int b = 0; b < nb; b++)
            for (int l = 0; l < BUS_NUM; l++) vec[b][l] = (l % 2 == 0) ? even_v : odd_v;
    endtask

    task automatic fill_rand(input int nb);
        for (int b = 0; b < nb; b++)
            for (int l = 0; l < BUS_NUM; l++) vec[b][l] = int'($urandom_range(0, 255)) - 128;
    endtask

    // rmode: 0 = always ready, 1 = 1,0,0,1 from first valid, 2 = random ready
    task automatic run_vec(input int k, input int sh, input int scale, input int sdly,
                           input int rmode, input string tag);
        int nb, scale_neg, exp_first, got, first_vld, rdy_i, last_neg, n;
        bit prev_stall, done;
        logic [BW-1:0] prev_data;
        logic [BUS_NUM-1:0] prev_mask;
        int pat [4];
        pat = '{1, 0, 0, 1};
        nb = (k + BUS_NUM - 1) / BUS_NUM;
        scale_neg = (nb + sdly < 1) ? 1 : nb + sdly;
        exp_first = ((scale_neg > nb) ? scale_neg : nb) + 4;
        got = 0; first_vld = -1; rdy_i = 0; last_neg = -10; n = 0;
        prev_stall = 0; done = 0; prev_data = '0; prev_mask = '0;
        while (!done && n < 3000) begin
            @(negedge clk);
            if (prev_stall) begin
                chk({tag, "_hold_vld"}, out_data_vld, 1);
                chk({tag, "_hold_data"}, out_data, prev_data);
                chk({tag, "_hold_mask"}, out_lane_mask, prev_mask);
            end
            start = (n == 0);
            k_len = DNW'(k);
            out_shift = SHW'(sh);
            in_fixed_data_vld = (n >= 1 && n <= nb);
            in_fixed_data = (n >= 1 && n <= nb) ? pack_beat(n - 1) : '0;
            rc_scale_vld = (n == scale_neg);
            rc_scale = SW'(scale);
            if (out_data_vld && first_vld < 0) begin
                first_vld = n;
                chk({tag, "_latency"}, 64'(n), 64'(exp_first));
            end
            if (rmode == 0 || first_vld < 0) out_rdy = 1'b1;
            else if (rmode == 1) begin
                out_rdy = (rdy_i < 4) ? pat[rdy_i] != 0 : 1'b1;
                rdy_i++;
            end else out_rdy = ($urandom_range(0, 3) != 0);
            if (n == last_neg + 1) begin
                chk({tag, "_busy_end"}, busy, 0);
                chk({tag, "_vld_end"}, out_data_vld, 0);
                done = 1;
            end else if (out_data_vld && out_rdy) begin
                if (got < nb) begin
                    chk($sformatf("%s_data%0d", tag, got), out_data, exp_data(got, k, scale, sh));
                    chk($sformatf("%s_mask%0d", tag, got), out_lane_mask, exp_mask(got, k));
                    chk($sformatf("%s_busy%0d", tag, got), busy, 1);
                    if (got == 0) cap0 = out_data;
                    cap_mask_last = out_lane_mask;
                    got++;
                    if (got == nb) last_neg = n;
                end else chk({tag, "_extra_beat"}, out_data_vld, 0);
            end
            prev_stall = out_data_vld && !out_rdy;
            prev_data = out_data;
            prev_mask = out_lane_mask;
            n++;
        end
        chk({tag, "_completed"}, 64'(done), 1);
        chk({tag, "_no_overflow"}, overflow_err, 0);
        start = 0; in_fixed_data_vld = 0; rc_scale_vld = 0; out_rdy = 1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_out_data", out_data, 0);
        chk("rst_mask", out_lane_mask, 0);
        chk("rst_vld", out_data_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        fill_const(2, 10, 10);
        run_vec(16, 8, 256, 20, 0, "k16");
        chk("k16_lit", cap0, 64'h0A0A0A0A0A0A0A0A);

        fill_const(1, 127, -128);
        run_vec(8, 8, 1024, 2, 0, "sat");
        chk("sat_lit", cap0, 64'h807F807F807F807F);

        fill_const(1, -3, 3);
        run_vec(8, 8, 128, 1, 0, "round");
        chk("round_lit", cap0, 64'h02FF02FF02FF02FF);

        fill_rand(2);
        run_vec(10, 0, 1, 3, 0, "k10");
        chk("k10_last_mask", cap_mask_last, 8'h03);

        fill_rand(3);
        run_vec(24, 6, 77, 0, 1, "coinc");

        for (int t = 0; t < 5; t++) begin
            int k, sh, sc, sd;
            k  = $urandom_range(1, 1023);
            sh = $urandom_range(0, 20);
            sc = int'($urandom_range(0, 24'hFFFFFF) >> $urandom_range(0, 23));
            sd = $urandom_range(0, 8) - 3;
            fill_rand((k + BUS_NUM - 1) / BUS_NUM);
            run_vec(k, sh, sc, sd, 2, $sformatf("rnd%0d", t));
        end

        // K=0 start must be ignored
        @(negedge clk); start = 1; k_len = '0;
        @(negedge clk); start = 0;
        repeat (3) begin
            @(negedge clk);
            chk("k0_busy", busy, 0);
            chk("k0_vld", out_data_vld, 0);
        end

        // beat while idle is dropped and flags a sticky error
        @(negedge clk); in_fixed_data_vld = 1; in_fixed_data = '1;
        @(negedge clk); in_fixed_data_vld = 0;
        chk("ovf_set", overflow_err, 1);
        repeat (4) @(negedge clk);
        chk("ovf_sticky", overflow_err, 1);

        // reset while output is stalled in DRAIN
        fill_rand(2);
        @(negedge clk); start = 1; k_len = 16; out_shift = 4; out_rdy = 0;
        @(negedge clk); start = 0; in_fixed_data_vld = 1; in_fixed_data = pack_beat(0);
        @(negedge clk); in_fixed_data = pack_beat(1);
        @(negedge clk); in_fixed_data_vld = 0; rc_scale_vld = 1; rc_scale = 100;
        @(negedge clk); rc_scale_vld = 0;
        for (int w = 0; w < 20 && !out_data_vld; w++) @(negedge clk);
        chk("mid_vld_before_rst", out_data_vld, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_mask", out_lane_mask, 0);
        chk("mid_rst_vld", out_data_vld, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_overflow", overflow_err, 0);
        @(negedge clk); rst_n = 1'b1; out_rdy = 1;
        @(negedge clk);
        fill_rand(4);
        run_vec(30, 5, 300, 2, 2, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
